// File: rtl/jpeg_stream_quantizer.sv
// Streaming table-driven JPEG quantizer: one coefficient per cycle through a 3-stage pipeline.
// It uses runtime-programmable reciprocal tables. Optional macro: QUANT_SAT_EN clamps the
// result; without it the result wraps.
module jpeg_stream_quantizer #(
    parameter int IN_WIDTH    = 11,
    parameter int OUT_WIDTH   = 11,
    parameter int FRAC_BITS   = 12,
    parameter int RECIP_WIDTH = 13,
    parameter int NUM_TABLES  = 2,
    localparam int TSW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    input  logic [TSW-1:0]               in_tsel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_last,
    input  logic                         tbl_we,
    input  logic [TSW-1:0]               tbl_sel,
    input  logic [5:0]                   tbl_addr,
    input  logic [RECIP_WIDTH-1:0]       tbl_data
);
    localparam int PW = IN_WIDTH + RECIP_WIDTH + 1;
    localparam logic [RECIP_WIDTH-1:0] RECIP_ONE = RECIP_WIDTH'(2 ** FRAC_BITS);
    localparam logic [PW-1:0] HALF = PW'(2 ** (FRAC_BITS - 1));

    logic [RECIP_WIDTH-1:0]       r_tbl [NUM_TABLES][64];
    logic [5:0]                   r_idx;
    logic [TSW-1:0]               r_blkTsel;
    logic                         r_v1;
    logic                         r_last1;
    logic signed [IN_WIDTH-1:0]   r_coef1;
    logic [RECIP_WIDTH-1:0]       r_recip1;
    logic                         r_v2;
    logic                         r_last2;
    logic signed [PW-1:0]         r_prod2;
    logic                         r_outValid;
    logic                         r_outLast;
    logic signed [OUT_WIDTH-1:0]  r_outData;

    logic                         w_stall;
    logic                         w_accept;
    logic [TSW-1:0]               w_curTsel;
    logic [TSW-1:0]               w_lookupTsel;
    logic [RECIP_WIDTH-1:0]       w_recip;
    logic signed [PW-1:0]         w_coefExt;
    logic signed [PW-1:0]         w_recipExt;
    logic                         w_neg;
    logic [PW-1:0]                w_mag;
    logic [PW-1:0]                w_rnd;
    logic [OUT_WIDTH-1:0]         w_q;

    // A held output freezes every stage, so upstream sees the stall the same cycle.
    assign w_stall   = r_outValid && !out_ready;
    assign w_accept  = in_valid && !w_stall;
    assign in_ready  = !w_stall;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;

    always_comb begin
        w_curTsel    = (r_idx == 6'd0) ? in_tsel : r_blkTsel;
        w_lookupTsel = w_curTsel;
        if (int'(w_curTsel) >= NUM_TABLES) begin
            w_lookupTsel = '0;
        end
        w_recip = r_tbl[w_lookupTsel][r_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                for (int e = 0; e < 64; e++) begin
                    r_tbl[t][e] <= RECIP_ONE;
                end
            end
        end else if (tbl_we && (int'(tbl_sel) < NUM_TABLES)) begin
            r_tbl[tbl_sel][tbl_addr] <= tbl_data;
        end
    end

    // The table select is captured only with the first coefficient of each block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_blkTsel <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd0) begin
                r_blkTsel <= in_tsel;
            end
        end
    end

    assign w_coefExt  = PW'(r_coef1);
    assign w_recipExt = $signed(PW'(r_recip1));
    assign w_neg      = r_prod2[PW-1];
    assign w_mag      = w_neg ? -r_prod2 : r_prod2;
    assign w_rnd      = (w_mag + HALF) >> FRAC_BITS;

`ifdef QUANT_SAT_EN
    localparam logic signed [PW-1:0] OUT_MAX = PW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] OUT_MIN = ~OUT_MAX;
    logic signed [PW-1:0] w_res;

    assign w_res = w_neg ? -$signed(w_rnd) : $signed(w_rnd);

    always_comb begin
        w_q = w_res[OUT_WIDTH-1:0];
        if (w_res > OUT_MAX) begin
            w_q = OUT_MAX[OUT_WIDTH-1:0];
        end else if (w_res < OUT_MIN) begin
            w_q = OUT_MIN[OUT_WIDTH-1:0];
        end
    end
`else
    assign w_q = w_neg ? OUT_WIDTH'(-w_rnd) : OUT_WIDTH'(w_rnd);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_last1    <= 1'b0;
            r_coef1    <= '0;
            r_recip1   <= '0;
            r_v2       <= 1'b0;
            r_last2    <= 1'b0;
            r_prod2    <= '0;
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            r_outData  <= '0;
        end else if (!w_stall) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_coef1  <= in_data;
                r_recip1 <= w_recip;
                r_last1  <= (r_idx == 6'd63);
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prod2 <= w_coefExt * w_recipExt;
                r_last2 <= r_last1;
            end
            r_outValid <= r_v2;
            r_outLast  <= r_v2 && r_last2;
            if (r_v2) begin
                r_outData <= w_q;
            end
        end
    end
endmodule

// File: tb/tb_jpeg_stream_quantizer.sv
// Randomized self-checking bench for jpeg_stream_quantizer. It checks against a queue-based
// reference model that quantizes with plain integer arithmetic.
module tb_jpeg_stream_quantizer;
    localparam int IN_W  = 11;
    localparam int OUT_W = 11;
    localparam int FRAC  = 12;
    localparam int RW    = 13;
    localparam int NT    = 2;
    localparam longint NONE = 100000;
`ifdef QUANT_SAT_EN
    localparam longint BIG_POS = 1023;
    localparam longint BIG_NEG = -1024;
`else
    localparam longint BIG_POS = -2;
    localparam longint BIG_NEG = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data = '0;
    logic [0:0]               in_tsel = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;
    logic                     tbl_we = 1'b0;
    logic [0:0]               tbl_sel = '0;
    logic [5:0]               tbl_addr = '0;
    logic [RW-1:0]            tbl_data = '0;

    jpeg_stream_quantizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tsel(in_tsel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: tables, block index, latched table and expected outputs in order.
    longint mTbl [NT][64];
    int     mIdx;
    int     mTsel;
    longint expData [$];
    bit     expLast [$];
    longint obsQ [$];
    int     cyc = 0;
    bit     prevStall = 0;
    longint prevData = 0;
    bit     latArm = 0;
    bit     latWait = 0;
    int     latAcc = 0;
    int     lastCnt = 0;
    int     stallCnt = 0;

    function automatic longint quant(input longint coef, input longint recip);
        longint p;
        longint r;
        p = coef * recip;
        if (p >= 0) r = (p + 2048) / 4096;
        else        r = -((-p + 2048) / 4096);
`ifdef QUANT_SAT_EN
        if (r > 1023) r = 1023;
        if (r < -1024) r = -1024;
`else
        r = r & 2047;
        if (r >= 1024) r = r - 2048;
`endif
        return r;
    endfunction

    task automatic modelReset();
        for (int t = 0; t < NT; t++)
            for (int e = 0; e < 64; e++) mTbl[t][e] = 4096;
        mIdx = 0;
        mTsel = 0;
        expData.delete();
        expLast.delete();
        prevStall = 0;
        latWait = 0;
    endtask

    always @(posedge clk) cyc++;

    // Inputs change just after posedge, so negedge values are what the next posedge samples.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (prevStall) begin
                checkOutput("hold_data", longint'(out_data), prevData);
                checkOutput("hold_valid", longint'(out_valid), 1);
            end
            prevStall = out_valid && !out_ready;
            prevData = longint'(out_data);
            if (prevStall) stallCnt++;
            if (latWait && out_valid) begin
                checkOutput("latency", cyc - latAcc, 3);
                latWait = 0;
            end
            if (out_valid && out_ready) begin
                obsQ.push_back(longint'(out_data));
                if (out_last) lastCnt++;
                if (expData.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    checkOutput("out_data", longint'(out_data), expData.pop_front());
                    checkOutput("out_last", longint'(out_last), longint'(expLast.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                int t;
                if (mIdx == 0) mTsel = int'(in_tsel);
                t = (mTsel >= NT) ? 0 : mTsel;
                expData.push_back(quant(longint'(in_data), mTbl[t][mIdx]));
                expLast.push_back(mIdx == 63);
                mIdx = (mIdx + 1) % 64;
                if (latArm) begin
                    latAcc = cyc;
                    latArm = 0;
                    latWait = 1;
                end
            end
            if (tbl_we && int'(tbl_sel) < NT) mTbl[tbl_sel][tbl_addr] = longint'(tbl_data);
        end
    end

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        modelReset();
        @(negedge clk);
        checkOutput("rst_out_valid", longint'(out_valid), 0);
        checkOutput("rst_out_data", longint'(out_data), 0);
        checkOutput("rst_out_last", longint'(out_last), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic writeTbl(input int sel, input int addr, input int data);
        tbl_we = 1'b1;
        tbl_sel = 1'(sel);
        tbl_addr = 6'(addr);
        tbl_data = RW'(data);
        @(posedge clk);
        #1;
        tbl_we = 1'b0;
    endtask

    task automatic sendCoef(input longint coef, input int tsel);
        int n = 0;
        bit acc = 0;
        in_valid = 1'b1;
        in_data = IN_W'(coef);
        in_tsel = 1'(tsel);
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int n, input int tsel, input longint firstCoef,
                                 input bit ramp, input bit gaps, input bit shake);
        for (int i = 0; i < n; i++) begin
            longint c;
            int ts;
            if (ramp) c = i;
            else if (i == 0 && firstCoef != NONE) c = firstCoef;
            else c = longint'($urandom_range(2047)) - 1024;
            ts = (shake && i > 0) ? int'($urandom_range(1)) : tsel;
            sendCoef(c, ts);
            if (gaps && $urandom_range(3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        out_ready = 1'b1;
        while (expData.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drain", expData.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        modelReset();
        resetDut();

        // Identity table: ramp in, ramp out, one out_last, 3-cycle latency.
        base = obsQ.size();
        lastCnt = 0;
        latArm = 1;
        applyStimulus(64, 0, NONE, 1, 0, 0);
        waitDrain();
        for (int i = 0; i < 64; i++) checkOutput("identity", obsQ[base + i], i);
        checkOutput("last_count", lastCnt, 1);

        // Q=16 on entry 0: symmetric rounding half away from zero.
        writeTbl(0, 0, 256);
        base = obsQ.size();
        applyStimulus(64, 0, 24, 0, 1, 0);
        applyStimulus(64, 0, -24, 0, 1, 0);
        applyStimulus(64, 0, 23, 0, 1, 0);
        applyStimulus(64, 0, -8, 0, 1, 0);
        waitDrain();
        checkOutput("q16_p24", obsQ[base], 2);
        checkOutput("q16_m24", obsQ[base + 64], -2);
        checkOutput("q16_p23", obsQ[base + 128], 1);
        checkOutput("q16_m8", obsQ[base + 192], -1);

        // Five-cycle backpressure mid-block.
        stallCnt = 0;
        fork
            applyStimulus(64, 0, NONE, 0, 0, 0);
            begin
                repeat (20) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("stall_cycles", stallCnt, 5);

        // Two tables, back-to-back blocks, in_tsel shaken mid-block.
        for (int e = 0; e < 64; e++) writeTbl(0, e, 4096);
        for (int e = 0; e < 64; e++) writeTbl(1, e, 512);
        base = obsQ.size();
        applyStimulus(64, 0, 100, 0, 0, 1);
        applyStimulus(64, 1, 100, 0, 0, 1);
        waitDrain();
        checkOutput("tsel0_100", obsQ[base], 100);
        checkOutput("tsel1_100", obsQ[base + 64], 13);

        // Large reciprocal: saturation or wrap.
        writeTbl(0, 0, 8191);
        base = obsQ.size();
        applyStimulus(64, 0, 1023, 0, 0, 0);
        applyStimulus(64, 0, -1024, 0, 0, 0);
        waitDrain();
        checkOutput("big_pos", obsQ[base], BIG_POS);
        checkOutput("big_neg", obsQ[base + 64], BIG_NEG);

        // Random blocks, random backpressure and concurrent table writes.
        fork
            for (int b = 0; b < 4; b++) applyStimulus(64, int'($urandom_range(1)), NONE, 0, 1, 1);
            begin
                repeat (300) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
            begin
                repeat (30) begin
                    repeat ($urandom_range(8, 2)) @(posedge clk);
                    #1;
                    writeTbl(int'($urandom_range(1)), int'($urandom_range(63)),
                             ($urandom_range(7) == 0) ? 0 : int'($urandom_range(8191)));
                end
            end
        join
        waitDrain();

        // Reset after 20 coefficients: index and tables return to defaults.
        applyStimulus(20, 0, NONE, 0, 0, 0);
        resetDut();
        base = obsQ.size();
        applyStimulus(64, 0, 500, 0, 0, 0);
        waitDrain();
        checkOutput("post_rst_q1", obsQ[base], 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
